// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO register file with iterative radix-2 multiply/divide engine
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mfhi,
  input  logic             mflo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] data_out
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, bz_q, bz_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d, done_q, done_d;
  logic sgn, sa, sb, ge;
  logic [WIDTH:0] msum, sh;
  logic [WIDTH-1:0] dsub;
  logic [2*WIDTH-1:0] prod;
  assign sgn  = op == 3'd1 || op == 3'd3;
  assign sa   = sgn & a[WIDTH-1];
  assign sb   = sgn & b[WIDTH-1];
  assign msum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
  // rem_q < dvs_q holds between steps, so the shifted partial remainder needs one extra bit
  assign sh   = {rem_q, quo_q[WIDTH-1]};
  assign ge   = sh >= {1'b0, dvs_q};
  assign dsub = sh[WIDTH-1:0] - dvs_q;
  assign prod = {rem_q, quo_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    div_d   = div_q;
    bz_d    = bz_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (op >= 3'd1 && op <= 3'd4) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = sa ? -a : a;
          dvs_d   = sb ? -b : b;
          a_d     = a;
          div_d   = op >= 3'd3;
          bz_d    = b == '0;
          neg_p_d = sa ^ sb;
          neg_r_d = sa;
        end
        hi_d = op == 3'd5 ? a : hi_q;
        lo_d = op == 3'd6 ? a : lo_q;
      end
      CALC: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = cnt_q == CNT_W'(WIDTH - 1) ? FIN : CALC;
        rem_d   = div_q ? (ge ? dsub : sh[WIDTH-1:0]) : msum[WIDTH:1];
        quo_d   = div_q ? {quo_q[WIDTH-2:0], ge} : {msum[0], quo_q[WIDTH-1:1]};
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (div_q) begin
          lo_d = bz_q ? '1 : neg_p_q ? -quo_q : quo_q;
          hi_d = bz_q ? a_q : neg_r_q ? -rem_q : rem_q;
        end else begin
          {hi_d, lo_d} = neg_p_q ? -prod : prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      bz_q    <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      div_q   <= div_d;
      bz_q    <= bz_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign data_out = mfhi ? hi_q : mflo ? lo_q : '0;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and random checks of hilo_muldiv_unit against an arithmetic model
module tb_hilo_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, start, mfhi, mflo, busy, done;
  logic [2:0] op;
  logic [W-1:0] a, b, hi, lo, data_out;
  logic [W-1:0] ref_hi = '0, ref_lo = '0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mfhi(mfhi), .mflo(mflo), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .data_out(data_out)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd1: begin p = sx * sy; return p; end
      3'd2: begin p = 64'(x) * 64'(y); return p; end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        p = {32'd0, x / y};
        p[63:32] = x % y;
        return p;
      end
      default: return {ref_hi, ref_lo};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit gap);
    logic [63:0] e;
    int n;
    e = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0; mfhi = 1'b1;
    chk("busy_after_accept", W'(busy), 1);
    #1 chk("data_out_during_busy", data_out, ref_hi);
    mfhi = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 100);
    chk("latency", W'(n), W + 1);
    chk("done_high", W'(done), 1);
    chk("busy_in_done", W'(busy), 0);
    ref_hi = e[63:32];
    ref_lo = e[31:0];
    chk("hi", hi, ref_hi);
    chk("lo", lo, ref_lo);
    if (gap) begin
      @(posedge clk);
      #1 chk("done_single_pulse", W'(done), 0);
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [W-1:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    if (o == 3'd5) ref_hi = x;
    if (o == 3'd6) ref_lo = x;
    chk("mt_busy", W'(busy), 0);
    chk("mt_hi", hi, ref_hi);
    chk("mt_lo", lo, ref_lo);
  endtask

  initial begin
    logic [2:0] ro;
    logic [W-1:0] rx, ry;
    bit seen;
    int n;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; mfhi = 1'b0; mflo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_data_out", data_out, 0);
    @(negedge clk) rst = 1'b0;

    mt(3'd5, 32'hAAAA_5555);
    mt(3'd6, 32'h0000_1357);
    mt(3'd0, 32'hDEAD_BEEF);
    mt(3'd7, 32'hDEAD_BEEF);

    // async reset in the middle of a MULTU
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    ref_hi = '0; ref_lo = '0;
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1 if (done) seen = 1'b1; end
    chk("midrst_no_done", W'(seen), 0);
    chk("midrst_lo_kept", lo, 0);

    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd100, 32'd7, 1'b1);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 1'b1);
    chk("divu_by0_lo", lo, 32'hFFFF_FFFF);
    chk("divu_by0_hi", hi, 32'd5);
    run_op(3'd3, 32'hFFFF_FFF0, 32'd0, 1'b1);
    chk("div_by0_hi", hi, 32'hFFFF_FFF0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    mt(3'd5, 32'h0000_1234);
    mt(3'd6, 32'h0000_5678);
    mfhi = 1'b1; mflo = 1'b1;
    #1 chk("mfhi_priority", data_out, 32'h0000_1234);
    mfhi = 1'b0;
    #1 chk("mflo_read", data_out, 32'h0000_5678);
    mflo = 1'b0;
    #1 chk("no_select", data_out, 32'd0);

    // MTLO issued while a DIVU is busy must be dropped
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h0000_DEAD; b = 32'd1;
    @(negedge clk);
    start = 1'b0; op = 3'd0; mflo = 1'b1;
    #1 chk("busy_mtlo_ignored", data_out, 32'h0000_5678);
    mflo = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("busy_mt_done", W'(done), 1);
    chk("busy_mt_lo", lo, 32'd14);
    chk("busy_mt_hi", hi, 32'd2);
    ref_hi = 32'd2; ref_lo = 32'd14;

    // back-to-back: second request issued in the done cycle of the first
    run_op(3'd2, 32'd12345, 32'd678, 1'b0);
    run_op(3'd3, 32'hFFFF_0000, 32'd3, 1'b0);
    run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(1, 4));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) ry = '0;
      else if ($urandom_range(0, 3) == 0) ry = W'($urandom_range(1, 20));
      run_op(ro, rx, ry, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
